// File: rtl/fir_unfolded_ctrl.sv
// fir_unfolded_ctrl: coefficient bank, serial<->3-lane packing and run/drain sequencing
// for a 3-parallel unfolded 9-tap FIR.
module fir_unfolded_ctrl #(
    parameter int NB = 11,
    parameter int NT = 9,
    parameter int OBUF_DEPTH = 2,
    parameter int OUTST_W = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          COEF_WE,
    input  logic [3:0]    COEF_ADDR,
    input  logic [NB-1:0] COEF_DATA,
    input  logic          START,
    input  logic          STOP,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    output logic [NB-1:0] DINK0,
    output logic [NB-1:0] DINK1,
    output logic [NB-1:0] DINK2,
    output logic          VOUT_K,
    output logic [NB-1:0] H0,
    output logic [NB-1:0] H1,
    output logic [NB-1:0] H2,
    output logic [NB-1:0] H3,
    output logic [NB-1:0] H4,
    output logic [NB-1:0] H5,
    output logic [NB-1:0] H6,
    output logic [NB-1:0] H7,
    output logic [NB-1:0] H8,
    input  logic [NB-1:0] DOUTK0,
    input  logic [NB-1:0] DOUTK1,
    input  logic [NB-1:0] DOUTK2,
    input  logic          VIN_K,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic          COEF_OK,
    output logic          BUSY,
    output logic          ERR
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
    localparam int PW = OBUF_DEPTH > 1 ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(OBUF_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(OBUF_DEPTH);

    logic [1:0]         state, cnt, ln, pad;
    logic               one;
    logic [NB-1:0]      h [NT];
    logic [NT-1:0]      mask;
    logic [NB-1:0]      l0, l1, lane;
    logic [OUTST_W-1:0] outst;
    logic [3*NB-1:0]    bd [OBUF_DEPTH];
    logic [1:0]         bn [OBUF_DEPTH];
    logic [PW-1:0]      rd, wr;
    logic [CW-1:0]      count;
    logic               acc_k, emit, last, pop, push, trunc, done;

    assign {H0, H1, H2, H3, H4, H5, H6, H7, H8} = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7], h[8]};
    assign COEF_OK = &mask;
    assign BUSY = state != IDLE;
    assign acc_k = VIN_K && outst != '0;
    assign emit = count != '0;
    assign last = ln == bn[rd] - 2'd1;
    assign pop = emit && last;
    assign push = acc_k && (count != FULL || pop);
    // Once drain has issued the padded block, it is the one that brings outstanding to zero.
    assign trunc = state == DRAIN && pad != '0 && outst == OUTST_W'(1) && !VOUT_K;
    assign done = cnt == '0 && outst == '0 && count == '0 && !VOUT_K;
    assign lane = ln == 2'd0 ? bd[rd][3*NB-1 -: NB] : ln == 2'd1 ? bd[rd][2*NB-1 -: NB] : bd[rd][NB-1:0];

    always_ff @(posedge CLK) begin
        if (push) begin
            bd[wr] <= {DOUTK0, DOUTK1, DOUTK2};
            bn[wr] <= trunc ? 2'd3 - pad : 2'd3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            ln     <= '0;
            pad    <= '0;
            one    <= 1'b0;
            mask   <= '0;
            l0     <= '0;
            l1     <= '0;
            outst  <= '0;
            rd     <= '0;
            wr     <= '0;
            count  <= '0;
            DINK0  <= '0;
            DINK1  <= '0;
            DINK2  <= '0;
            VOUT_K <= 1'b0;
            DOUT   <= '0;
            VOUT   <= 1'b0;
            ERR    <= 1'b0;
            for (int i = 0; i < NT; i++) h[i] <= '0;
        end else begin
            VOUT_K <= 1'b0;
            VOUT   <= emit;
            if (state == IDLE) begin
                if (COEF_WE && COEF_ADDR < 4'(NT)) begin
                    h[COEF_ADDR]    <= COEF_DATA;
                    mask[COEF_ADDR] <= 1'b1;
                end
                if (START && COEF_OK) begin
                    state <= RUN;
                    cnt   <= '0;
                    pad   <= '0;
                    one   <= 1'b0;
                end
            end else if (state == RUN) begin
                if (VIN) begin
                    cnt <= cnt == 2'd2 ? 2'd0 : cnt + 2'd1;
                    if (cnt == 2'd0) l0 <= DIN;
                    if (cnt == 2'd1) l1 <= DIN;
                    if (cnt == 2'd2) begin
                        {DINK0, DINK1, DINK2} <= {l0, l1, DIN};
                        VOUT_K <= 1'b1;
                    end
                end
                if (STOP) state <= DRAIN;
            end else if (cnt == 2'd1) begin
                l1  <= '0;
                cnt <= 2'd2;
                one <= 1'b1;
            end else if (cnt == 2'd2) begin
                {DINK0, DINK1, DINK2} <= {l0, l1, {NB{1'b0}}};
                VOUT_K <= 1'b1;
                cnt    <= '0;
                pad    <= one ? 2'd2 : 2'd1;
            end else if (done) begin
                state <= IDLE;
            end
            outst <= outst + OUTST_W'(VOUT_K) - OUTST_W'(acc_k);
            if (push) wr <= wr == LAST ? '0 : wr + 1'b1;
            if (acc_k && !push) ERR <= 1'b1;
            if (emit) begin
                DOUT <= lane;
                ln   <= last ? 2'd0 : ln + 2'd1;
            end
            if (pop) rd <= rd == LAST ? '0 : rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fir_unfolded_ctrl.sv
// tb_fir_unfolded_ctrl: directed stimulus with a queue scoreboard for lane blocks and serial output.
module tb_fir_unfolded_ctrl;
    logic        CLK = 1'b0, RST = 1'b1, COEF_WE = 1'b0, START = 1'b0, STOP = 1'b0, VIN = 1'b0;
    logic [3:0]  COEF_ADDR = '0;
    logic [10:0] COEF_DATA = '0, DIN = '0;
    logic [10:0] DINK0, DINK1, DINK2, DOUT, DOUTK0, DOUTK1, DOUTK2;
    logic [10:0] H0, H1, H2, H3, H4, H5, H6, H7, H8;
    logic        VOUT_K, VOUT, COEF_OK, BUSY, ERR, VIN_K;
    logic        lb_en = 1'b1;
    logic [33:0] d1 = '0, d2 = '0, lb = '0, man = '0;
    logic [32:0] exp_blk [$];
    int          exp_out [$];
    logic [32:0] mb;
    int          checks = 0, errors = 0, run = 0, max_run = 0;

    fir_unfolded_ctrl dut (
        .CLK(CLK), .RST(RST), .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
        .START(START), .STOP(STOP), .DIN(DIN), .VIN(VIN),
        .DINK0(DINK0), .DINK1(DINK1), .DINK2(DINK2), .VOUT_K(VOUT_K),
        .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6), .H7(H7), .H8(H8),
        .DOUTK0(DOUTK0), .DOUTK1(DOUTK1), .DOUTK2(DOUTK2), .VIN_K(VIN_K),
        .DOUT(DOUT), .VOUT(VOUT), .COEF_OK(COEF_OK), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    assign {VIN_K, DOUTK0, DOUTK1, DOUTK2} = lb_en ? lb : man;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [32:0] blk(input int a, input int b, input int c);
        return {11'(a), 11'(b), 11'(c)};
    endfunction

    // Identity FIR: each issued block comes back as an output block two cycles later.
    always @(negedge CLK) begin
        lb = d2;
        d2 = d1;
        d1 = {VOUT_K, DINK0, DINK1, DINK2};
    end

    always @(negedge CLK) begin
        run = VOUT ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (VOUT_K) begin
            if (exp_blk.size() == 0) chk("unexpected_vout_k", 1, 0);
            else begin
                mb = exp_blk.pop_front();
                chk("dink0", int'(DINK0), int'(mb[32:22]));
                chk("dink1", int'(DINK1), int'(mb[21:11]));
                chk("dink2", int'(DINK2), int'(mb[10:0]));
            end
        end
        if (VOUT) begin
            if (exp_out.size() == 0) chk("unexpected_vout", 1, 0);
            else chk("dout", int'(DOUT), exp_out.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge CLK);
        COEF_WE = 1'b1;
        COEF_ADDR = 4'(a);
        COEF_DATA = 11'(d);
        @(negedge CLK);
        COEF_WE = 1'b0;
    endtask

    task automatic start_run();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic feed(input int v);
        @(negedge CLK);
        DIN = 11'(v);
        VIN = 1'b1;
    endtask

    task automatic idle_in();
        @(negedge CLK);
        VIN = 1'b0;
        STOP = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dink"}, int'(DINK0 | DINK1 | DINK2), 0);
        chk({tag, "_vout_k"}, int'(VOUT_K), 0);
        chk({tag, "_h"}, int'(H0 | H4 | H8), 0);
        chk({tag, "_dout"}, int'(DOUT), 0);
        chk({tag, "_vout"}, int'(VOUT), 0);
        chk({tag, "_coef_ok"}, int'(COEF_OK), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_err"}, int'(ERR), 0);
    endtask

    initial begin
        cyc(2);
        RST = 1'b0;
        chk_zero("reset");

        // eight coefficients plus an out-of-range address: not enough to start
        for (int i = 0; i < 8; i++) wr(i, i + 1);
        wr(9, 99);
        chk("coef_ok_8", int'(COEF_OK), 0);
        start_run();
        chk("busy_no_start", int'(BUSY), 0);
        wr(8, 9);
        chk("coef_ok_9", int'(COEF_OK), 1);
        chk("h0", int'(H0), 1);
        chk("h5", int'(H5), 6);
        chk("h8", int'(H8), 9);
        start_run();
        chk("busy_run", int'(BUSY), 1);
        wr(0, 77);
        chk("h0_frozen", int'(H0), 1);

        // two full blocks, looped back
        exp_blk.push_back(blk(1, 2, 3));
        exp_blk.push_back(blk(4, 5, 6));
        for (int i = 1; i <= 6; i++) begin
            feed(i);
            exp_out.push_back(i);
        end
        idle_in();
        cyc(15);
        chk("back_to_back_run", max_run, 6);

        // partial final block with STOP alongside the last sample
        exp_blk.push_back(blk(10, 11, 12));
        exp_blk.push_back(blk(13, 0, 0));
        for (int i = 10; i <= 13; i++) begin
            feed(i);
            exp_out.push_back(i);
        end
        STOP = 1'b1;
        idle_in();
        for (int i = 0; i < 60 && BUSY; i++) cyc(1);
        chk("drain_idle", int'(BUSY), 0);
        cyc(5);

        // overflow: three blocks outstanding, then three back-to-back output blocks
        lb_en = 1'b0;
        start_run();
        for (int i = 0; i < 3; i++) exp_blk.push_back(blk(21 + 3 * i, 22 + 3 * i, 23 + 3 * i));
        for (int i = 21; i <= 29; i++) feed(i);
        idle_in();
        cyc(2);
        for (int b = 0; b < 3; b++) begin
            @(negedge CLK);
            man = {1'b1, 11'(100 + 10 * b), 11'(101 + 10 * b), 11'(102 + 10 * b)};
            if (b < 2) for (int k = 0; k < 3; k++) exp_out.push_back(100 + 10 * b + k);
        end
        @(negedge CLK);
        man = '0;
        cyc(12);
        chk("err_set", int'(ERR), 1);
        chk("err_busy", int'(BUSY), 1);
        cyc(3);
        chk("err_sticky", int'(ERR), 1);
        pulse_rst();
        chk("err_cleared", int'(ERR), 0);
        chk("rst_busy", int'(BUSY), 0);

        // reset mid-block with one block outstanding
        for (int i = 0; i < 9; i++) wr(i, 20 + i);
        start_run();
        exp_blk.push_back(blk(31, 32, 33));
        for (int i = 31; i <= 35; i++) feed(i);
        idle_in();
        cyc(1);
        pulse_rst();
        chk_zero("abort");
        cyc(15);
        chk("abort_still_idle", int'(BUSY), 0);

        chk("blk_queue_empty", exp_blk.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/fir_unfolded_ctrl.md
Name: fir_unfolded_ctrl

Overview:
Sequencer for the 3-parallel unfolded 9-tap FIR (11-bit samples, coefficients H0..H8).
- Holds the coefficient bank and loads it through a write port.
- Packs a serial sample stream into 3-lane blocks (DINK0..2 plus a valid) for the FIR.
- Unpacks the FIR's 3-lane output blocks back into a serial stream.
- Controls run and drain, including the zero-padding of a final partial block.

Parameters:
NB, 11, sample and coefficient width
NT, 9, number of taps (H0..H8)
OBUF_DEPTH, 2, output block buffer depth in blocks
OUTST_W, 4, width of the outstanding-block counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
COEF_WE  in  1  coefficient write strobe
COEF_ADDR  in  4  coefficient index, 0..8
COEF_DATA  in  NB  coefficient value
START  in  1  begin run
STOP  in  1  end run and drain
DIN  in  NB  serial input sample
VIN  in  1  DIN valid
DINK0/DINK1/DINK2  out  NB  lanes k, k+1, k+2 to FIR
VOUT_K  out  1  lane block valid to FIR
H0..H8  out  NB each  coefficients to FIR
DOUTK0/DOUTK1/DOUTK2  in  NB  FIR output lanes
VIN_K  in  1  FIR output block valid
DOUT  out  NB  serial output sample
VOUT  out  1  DOUT valid
COEF_OK  out  1  all 9 coefficients written since reset
BUSY  out  1  state is not IDLE
ERR  out  1  sticky output-buffer overflow

Behaviour:
- One clock; reset is synchronous and active-high (RST sampled on the CLK rising edge).
- Reset values:
  - All outputs 0: H0..H8=0, DINK*=0, VOUT_K=0, DOUT=0, VOUT=0, COEF_OK=0, BUSY=0, ERR=0.
  - Internally: written-mask=0, lane counter=0, outstanding=0, buffer empty, pad=0, state=IDLE.
- Reset asserted mid-run aborts everything. No partial block is emitted.
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE:
  - COEF_WE with COEF_ADDR<=8 writes H[addr] on the next edge and sets that bit of the written-mask.
  - Addresses 9..15 are ignored.
  - COEF_OK = (mask==all ones).
  - START with COEF_OK=1 goes to RUN. START with COEF_OK=0 is ignored.
- In RUN and DRAIN, COEF_WE is ignored; H outputs stay frozen.
- RUN:
  - Each VIN=1 stores DIN in the lane given by the lane counter (0→DINK0, 1→DINK1, 2→DINK2), then increments the counter mod 3.
  - When the third sample is stored, DINK0..2 update and VOUT_K=1 for exactly one cycle, the cycle after that sample's VIN.
  - DINK* hold their value between blocks.
  - STOP goes to DRAIN. A VIN in the same cycle as STOP is still accepted.
- DRAIN:
  - VIN is ignored.
  - If the lane counter is non-zero, the remaining lanes are padded with 0 one per cycle. The block is then issued with VOUT_K, and pad = 3 − samples held.
  - Then wait until outstanding==0 and the buffer is empty, then go to IDLE.
- Outstanding counter:
  - +1 on VOUT_K, −1 on VIN_K; both in the same cycle leaves it unchanged.
  - VIN_K while outstanding==0 is ignored.
- Output path:
  - VIN_K pushes {DOUTK0, DOUTK1, DOUTK2} into the block buffer.
  - The unpacker emits lanes 0, 1, 2 on consecutive cycles with VOUT=1.
  - The first lane appears the cycle after the push, or after the previous block finishes.
  - Consecutive blocks are emitted back-to-back with no bubble.
  - For the block that brings outstanding to 0 in DRAIN with pad>0, only the first 3−pad lanes are emitted; padded results are suppressed.
  - DOUT holds its last value when VOUT=0.
- Buffer boundary conditions:
  - A push and a pop of the head block's last lane in the same cycle is legal when the buffer is full.
  - A push to a full buffer with no simultaneous pop drops the block and sets ERR (sticky until RST).
- FIR latency is not assumed: the controller tracks only VIN_K.

Test Plan:
1. Write H[i]=i+1 for i=0..8, then START → COEF_OK=1 after the 9th write; BUSY=1 the cycle after START.
2. Write only 8 coefficients, then START → stays IDLE, BUSY=0. Write H8, then START → RUN.
3. In RUN, feed DIN=1..6 on consecutive cycles → VOUT_K pulses twice with (1,2,3) and (4,5,6); loop VOUT_K back to VIN_K with a 2-cycle delay → DOUT=1..6 with VOUT on 6 consecutive cycles.
4. Feed 4 samples (10,11,12,13), then STOP → second block issued as (13,0,0) with pad=2; DOUT emits exactly 10,11,12,13; after the buffer empties, state returns to IDLE and BUSY=0.
5. Hold off unpacking with three VIN_K blocks on consecutive cycles → third block dropped, ERR=1 until RST.
6. Assert RST while mid-block with 2 samples held and 1 block outstanding → next cycle all outputs 0 and state IDLE; no VOUT_K or VOUT follows.
